// File: rtl/muldiv_iter_if.sv
// Request/result bundle for the iterative multiply/divide unit.
//   master (Execute stage): drives start, op, a, b, cancel; observes the results.
//   slave  (muldiv_iter):   observes the request; drives busy, ready, hi, lo, div_zero.
//   op encoding: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
interface muldiv_iter_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cancel;
   logic             busy;
   logic             ready;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_zero;

   modport master (
      output start, op, a, b, cancel,
      input  busy, ready, hi, lo, div_zero
   );

   modport slave (
      input  start, op, a, b, cancel,
      output busy, ready, hi, lo, div_zero
   );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide unit (MULTU, MULT, DIVU, DIV) for the Execute stage.
// Signed operations run on magnitudes and get their signs fixed in a single cycle at the end.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : muldiv_iter_if slave (start/op/a/b/cancel in; busy/ready/hi/lo/div_zero out)
// Results appear WIDTH+2 cycles after the start cycle. A divide by zero completes in 2 cycles.
module muldiv_iter #(
   parameter int unsigned WIDTH = 32
) (
   input logic          clk,
   input logic          reset,
   muldiv_iter_if.slave bus
);

   localparam logic [WIDTH-1:0] Zero    = '0;
   localparam logic [WIDTH-1:0] Ones    = '1;
   localparam logic [WIDTH-1:0] CntOne  = WIDTH'(1);
   localparam logic [WIDTH-1:0] CntLast = WIDTH'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;       // product, or {remainder, quotient}
   logic [WIDTH-1:0]   opb_q, opb_d;       // multiplicand or divisor magnitude
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               div_zero_q, div_zero_d;
   logic               busy_q, busy_d;
   logic               ready_q, ready_d;

   // Request decode
   logic             in_signed, in_div, b_zero;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign in_signed = bus.op[0];
   assign in_div    = bus.op[1];
   assign b_zero    = (bus.b == Zero);
   assign a_mag     = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign b_mag     = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   // Multiply step: add the multiplicand into the upper half when the multiplier LSB is set,
   // then shift right, keeping the carry.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {1'b0, Zero});
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Restoring divide step: shift in the next dividend bit and subtract when it fits.
   // The shifted remainder is below twice the divisor, so diff[WIDTH] is a clean borrow.
   logic [WIDTH:0]     div_shift, div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_next;

   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opb_q};
   assign div_ge    = ~div_diff[WIDTH];
   assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ge};

   // Sign fix-up values
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic [2*WIDTH-1:0] prod_fix;

   assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   assign prod_fix = neg_res_q ? -acc_q : acc_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opb_d      = opb_q;
      is_div_d   = is_div_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      dz_d       = dz_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;

      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (bus.start && !bus.cancel) begin
               cnt_d    = Zero;
               is_div_d = in_div;
               if (in_div && b_zero) begin
                  // Preload the fixed divide-by-zero result; FIX passes it through untouched.
                  acc_d     = {bus.a, Ones};
                  neg_res_d = 1'b0;
                  neg_rem_d = 1'b0;
                  dz_d      = 1'b1;
                  state_d   = StFix;
               end else begin
                  acc_d     = {Zero, (in_div ? a_mag : b_mag)};
                  opb_d     = in_div ? b_mag : a_mag;
                  neg_res_d = in_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  neg_rem_d = in_signed & bus.a[WIDTH-1];
                  dz_d      = 1'b0;
                  state_d   = StCalc;
               end
            end
         end
         StCalc: begin
            if (bus.cancel) begin
               state_d = StIdle;
            end else begin
               acc_d = is_div_q ? div_next : mul_next;
               cnt_d = cnt_q + CntOne;
               if (cnt_q == CntLast) begin
                  state_d = StFix;
               end
            end
         end
         StFix: begin
            if (bus.cancel) begin
               state_d = StIdle;
            end else begin
               if (is_div_q && !dz_q) begin
                  lo_d = quo_fix;
                  hi_d = rem_fix;
               end else begin
                  {hi_d, lo_d} = prod_fix;
               end
               div_zero_d = dz_q;
               state_d    = StDone;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d  = (state_d == StCalc) || (state_d == StFix);
      ready_d = (state_d == StDone);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         acc_q      <= '0;
         opb_q      <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         dz_q       <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         div_zero_q <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opb_q      <= opb_d;
         is_div_q   <= is_div_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         dz_q       <= dz_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         div_zero_q <= div_zero_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.ready    = ready_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: a WIDTH=32 instance checked every cycle against an arithmetic model,
// plus directed literal checks, and a WIDTH=8 instance for parameter coverage.
module tb_muldiv_iter;

   logic clk;
   logic rst_n;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   muldiv_iter_if #(.WIDTH(32)) bus32 ();
   muldiv_iter_if #(.WIDTH(8))  bus8 ();

   muldiv_iter #(.WIDTH(32)) u_dut32 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus32.slave)
   );

   muldiv_iter #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus8.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Arithmetic reference for a w-bit unit (w <= 32), straight from the op definitions.
   function automatic void model(input int w, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] hi,
                                 output logic [31:0] lo, output logic dz);
      logic [31:0] mask;
      logic [63:0] ua, ub, p;
      longint      sa, sb, q, r;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      ua   = {32'd0, a & mask};
      ub   = {32'd0, b & mask};
      sa   = longint'(ua);
      sb   = longint'(ub);
      if (ua[w-1]) sa = sa - (longint'(1) << w);
      if (ub[w-1]) sb = sb - (longint'(1) << w);
      dz = 1'b0;
      p  = 64'd0;
      case (op)
         2'b00: p = ua * ub;
         2'b01: p = 64'(sa * sb);
         default: begin
            if (ub == 64'd0) begin
               dz = 1'b1;
               hi = a & mask;
               lo = mask;
               return;
            end
            if (op == 2'b10) begin
               q = longint'(ua / ub);
               r = longint'(ua % ub);
            end else begin
               q = sa / sb;
               r = sa % sb;
            end
            lo = 32'(q) & mask;
            hi = 32'(r) & mask;
            return;
         end
      endcase
      lo = p[31:0] & mask;
      hi = 32'(p >> w) & mask;
   endfunction

   // ---- Model of the 32-bit unit: accept edge, latency, committed results ----
   logic        m_pend = 1'b0;
   int          m_k    = 0;
   int          m_lat  = 0;
   logic [31:0] m_xhi, m_xlo;
   logic        m_xdz;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
   logic        m_dz = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      logic        in_flight;
      logic [31:0] th, tl;
      logic        tdz;
      if (!rst_n) begin
         m_pend <= 1'b0;
         m_hi   <= 32'd0;
         m_lo   <= 32'd0;
         m_dz   <= 1'b0;
      end else begin
         // cyc still holds the index of the previous edge here
         in_flight = m_pend && (cyc >= m_k) && (cyc < m_k + m_lat);
         if (m_pend && (cyc + 1 == m_k + m_lat) && !bus32.cancel) begin
            m_hi <= m_xhi;
            m_lo <= m_xlo;
            m_dz <= m_xdz;
         end
         if (bus32.cancel) begin
            m_pend <= 1'b0;
         end else if (bus32.start && !in_flight) begin
            model(32, bus32.op, bus32.a, bus32.b, th, tl, tdz);
            m_pend <= 1'b1;
            m_k    <= cyc + 1;
            m_lat  <= tdz ? 1 : 33;
            m_xhi  <= th;
            m_xlo  <= tl;
            m_xdz  <= tdz;
         end
      end
   end

   // Every-cycle comparison of the 32-bit unit against the model
   always @(negedge clk) begin
      logic xb, xr;
      xb = m_pend && (cyc >= m_k) && (cyc < m_k + m_lat);
      xr = m_pend && (cyc == m_k + m_lat);
      chk("busy", 64'(bus32.busy), 64'(xb));
      chk("ready", 64'(bus32.ready), 64'(xr));
      chk("hi", 64'(bus32.hi), 64'(m_hi));
      chk("lo", 64'(bus32.lo), 64'(m_lo));
      chk("div_zero", 64'(bus32.div_zero), 64'(m_dz));
   end

   // Issue one op on the 32-bit unit and wait for ready; checks literals, latency, busy length.
   task automatic run32(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] xhi, input logic [31:0] xlo,
                        input logic xdz, input int xlat);
      int n, nb;
      bus32.op    = op;
      bus32.a     = a;
      bus32.b     = b;
      bus32.start = 1'b1;
      @(posedge clk);
      #1;
      bus32.start = 1'b0;
      bus32.a     = $urandom();
      bus32.b     = $urandom();
      bus32.op    = 2'($urandom());
      n  = 1;
      nb = 0;
      while (bus32.ready !== 1'b1 && n < 100) begin
         if (bus32.busy === 1'b1) nb++;
         @(posedge clk);
         #1;
         n++;
      end
      chk({name, "_latency"}, 64'(n), 64'(xlat));
      chk({name, "_busy_cycles"}, 64'(nb), 64'(xlat - 1));
      chk({name, "_hi"}, 64'(bus32.hi), 64'(xhi));
      chk({name, "_lo"}, 64'(bus32.lo), 64'(xlo));
      chk({name, "_div_zero"}, 64'(bus32.div_zero), 64'(xdz));
   endtask

   task automatic run8(input string name, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] xres);
      int n;
      logic [31:0] mh, ml;
      logic        mdz;
      model(8, op, {24'd0, a}, {24'd0, b}, mh, ml, mdz);
      bus8.op    = op;
      bus8.a     = a;
      bus8.b     = b;
      bus8.start = 1'b1;
      @(posedge clk);
      #1;
      bus8.start = 1'b0;
      n = 1;
      while (bus8.ready !== 1'b1 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({name, "_latency"}, 64'(n), 64'd10);
      chk({name, "_result"}, 64'({bus8.hi, bus8.lo}), 64'(xres));
      chk({name, "_model"}, 64'({bus8.hi, bus8.lo}), 64'({mh[7:0], ml[7:0]}));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic count_ready(input string name, input int n);
      int seen;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (bus32.ready === 1'b1) seen++;
      end
      chk(name, 64'(seen), 64'd0);
   endtask

   initial begin
      bus32.start = 1'b0; bus32.cancel = 1'b0; bus32.op = 2'b00; bus32.a = '0; bus32.b = '0;
      bus8.start  = 1'b0; bus8.cancel  = 1'b0; bus8.op  = 2'b00; bus8.a  = '0; bus8.b  = '0;
      rst_n = 1'b0;
      idle(3);
      chk("reset_busy", 64'(bus32.busy), 64'd0);
      chk("reset_ready", 64'(bus32.ready), 64'd0);
      chk("reset_hilo", 64'({bus32.hi, bus32.lo}), 64'd0);
      chk("reset_div_zero", 64'(bus32.div_zero), 64'd0);
      rst_n = 1'b1;
      idle(2);

      run32("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
            1'b0, 34);
      idle(1);
      run32("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
      run32("mult_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 34);
      idle(2);
      run32("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
      run32("divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
      run32("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34);
      idle(1);
      run32("divu_zero", 2'b10, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 2);
      // Back-to-back: start issued in the DONE cycle
      run32("multu_b2b", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 34);
      idle(1);
      run32("div_zero_s", 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 2);
      idle(1);

      // Cancel mid-CALC: no ready, previous results held
      bus32.op = 2'b10; bus32.a = 32'd1000; bus32.b = 32'd3; bus32.start = 1'b1;
      idle(1);
      bus32.start = 1'b0;
      idle(10);
      bus32.cancel = 1'b1;
      idle(1);
      bus32.cancel = 1'b0;
      chk("cancel_busy", 64'(bus32.busy), 64'd0);
      count_ready("cancel_no_ready", 40);
      chk("cancel_hold_hi", 64'(bus32.hi), 64'h0000_0000_FFFF_FFFB);
      chk("cancel_hold_lo", 64'(bus32.lo), 64'h0000_0000_FFFF_FFFF);
      chk("cancel_hold_dz", 64'(bus32.div_zero), 64'd1);

      // start and cancel together in IDLE: nothing happens
      bus32.op = 2'b00; bus32.a = 32'd5; bus32.b = 32'd5;
      bus32.start = 1'b1; bus32.cancel = 1'b1;
      idle(1);
      bus32.start = 1'b0; bus32.cancel = 1'b0;
      chk("start_cancel_busy", 64'(bus32.busy), 64'd0);
      count_ready("start_cancel_no_ready", 40);

      // Asynchronous reset mid-CALC
      bus32.op = 2'b00; bus32.a = 32'd77; bus32.b = 32'd99; bus32.start = 1'b1;
      idle(1);
      bus32.start = 1'b0;
      idle(5);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", 64'(bus32.busy), 64'd0);
      chk("async_rst_ready", 64'(bus32.ready), 64'd0);
      chk("async_rst_hilo", 64'({bus32.hi, bus32.lo}), 64'd0);
      chk("async_rst_dz", 64'(bus32.div_zero), 64'd0);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      run32("divu_after_rst", 2'b10, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, 34);
      idle(2);

      // WIDTH=8 instance
      run8("w8_mult_min", 2'b01, 8'h80, 8'h80, 16'h4000);
      run8("w8_multu_max", 2'b00, 8'hFF, 8'hFF, 16'hFE01);
      run8("w8_div_neg", 2'b11, 8'hF9, 8'h02, 16'hFFFD);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
